ecc_rd_ctrl: RTL and testbench
==============================

// Module: ecc_rd_ctrl
// PURPOSE
//  Read-side sequencer for the ECC-protected FIFO storage. Pops 39-bit words (32 data + 7 check) from the
//  storage RAM, presents them to the combinational SEC-DED decoder and registers the corrected data and
//  error flag into a valid/ready output stage. Owns the read pointer and accumulates a sticky error status.
// PARAMETERS
//  DATA_WIDTH  32  data bits per word; must equal the decoder's DATA_WIDTH
//  ECC_WIDTH   7   check bits per word; must equal the decoder's ECC_WIDTH
//  ADDR_WIDTH  4   RAM address width; depth = 2**ADDR_WIDTH
// PORTS
//  clk           in   1                      single clock; all state changes on rising edge
//  rst           in   1                      synchronous, active-high reset
//  fifo_empty    in   1                      storage holds no unread word (from pointer-compare logic)
//  mem_rd_en     out  1                      RAM read strobe; one cycle per word
//  mem_rd_addr   out  ADDR_WIDTH             RAM read address (= rd_ptr)
//  mem_rd_data   in   DATA_WIDTH+ECC_WIDTH   RAM data, valid 1 cycle after mem_rd_en; {check[6:0], data[31:0]}
//  dec_datain    out  DATA_WIDTH             registered data to decoder Datain
//  dec_corr      out  ECC_WIDTH              registered check bits to decoder Corr_data
//  dec_dataout   in   DATA_WIDTH             decoder corrected data
//  dec_err       in   1                      decoder m_error
//  rd_ptr        out  ADDR_WIDTH+1           read pointer incl. wrap bit, for full/empty compare
//  dout          out  DATA_WIDTH             corrected output word
//  dout_err      out  1                      word had a detected error (corrected or not)
//  dout_valid    out  1                      dout/dout_err valid
//  dout_ready    in   1                      consumer accepts when dout_valid & dout_ready
//  err_sticky    out  1                      set on any delivered word with dout_err; cleared by err_clr
//  err_clr       in   1                      clears err_sticky (and err_cnt when compiled in)
// BEHAVIOUR
//  - Reset: state=IDLE; rd_ptr=0; mem_rd_en=0; mem_rd_addr=0; dec_datain=0; dec_corr=0; dout=0;
//    dout_err=0; dout_valid=0; err_sticky=0. Reset mid-operation discards any in-flight read; rd_ptr is not rolled back.
//  - FSM (IDLE, RD, DEC, OUT):
//    IDLE: if !fifo_empty -> mem_rd_en=1, mem_rd_addr=rd_ptr, rd_ptr+=1, go RD; else stay.
//    RD:   capture mem_rd_data into dec_corr/dec_datain; go DEC.
//    DEC:  capture dec_dataout->dout, dec_err->dout_err; dout_valid=1; go OUT.
//    OUT:  hold dout/dout_err/dout_valid stable until dout_ready. On handshake: if !fifo_empty issue
//          next read in the same cycle (mem_rd_en=1, rd_ptr+=1, go RD, dout_valid=0 next cycle);
//          else dout_valid=0, go IDLE.
//  - mem_rd_en is a 1-cycle pulse, asserted only in IDLE or OUT-with-handshake and never when fifo_empty=1.
//  - Latency: read issue -> dout_valid = 3 clocks. Back-to-back throughput: one word per 3 clocks with
//    dout_ready held high.
//  - rd_ptr low ADDR_WIDTH bits wrap 2**ADDR_WIDTH-1 -> 0; MSB toggles on wrap.
//  - fifo_empty sampled only at issue points; deasserting it mid-word has no effect on the word in flight.
//  - err_sticky set on handshake cycle with dout_err=1; if err_clr in same cycle, set wins.
//  - dout_valid never drops without a handshake except on rst.
// CONFIGURATION
//  ECC_ERR_CNT_EN defined: adds output err_cnt [15:0]; increments on each handshake with dout_err=1,
//    saturates at 16'hFFFF; err_clr zeroes it (increment in same cycle wins -> 1); reset value 0.
//  ECC_ERR_CNT_EN undefined: no err_cnt port or counter; all other behaviour identical.
// TESTING
//  1. rst, fifo_empty=1 for 10 clks -> mem_rd_en never asserted, dout_valid=0, rd_ptr=0.
//  2. Clean word 32'hDEADBEEF w/ valid check bits at addr 0, dout_ready=1 -> dout=32'hDEADBEEF,
//     dout_err=0, dout_valid 3 clks after mem_rd_en, rd_ptr=1.
//  3. Same word with data bit 5 flipped -> dout=32'hDEADBEEF, dout_err=1, err_sticky=1; err_clr -> 0.
//  4. Double-bit flip -> dout_err=1; dout_ready=0 for 5 clks -> dout/dout_valid stable, no new mem_rd_en.
//  5. 17 words streamed, ADDR_WIDTH=4 -> addresses 0..15,0; rd_ptr ends 5'h11; data order preserved.
//  6. rst asserted in DEC -> next clk all outputs at reset values, no dout_valid for that word;
//     with ECC_ERR_CNT_EN: 3 error words -> err_cnt=3, err_clr -> 0.

Source files
------------

// File: rtl/ecc_rd_ctrl_if.sv
// Bus bundle between the ECC read sequencer and its RAM, its SEC-DED decoder and its downstream consumer.
// The master modport is the sequencer's view; the slave modport is the surrounding storage/decoder/sink.
interface ecc_rd_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ECC_WIDTH  = 7,
    parameter int ADDR_WIDTH = 4
);
    logic                             fifo_empty;
    logic                             mem_rd_en;
    logic [ADDR_WIDTH-1:0]            mem_rd_addr;
    logic [DATA_WIDTH+ECC_WIDTH-1:0]  mem_rd_data;
    logic [DATA_WIDTH-1:0]            dec_datain;
    logic [ECC_WIDTH-1:0]             dec_corr;
    logic [DATA_WIDTH-1:0]            dec_dataout;
    logic                             dec_err;
    logic [DATA_WIDTH-1:0]            dout;
    logic                             dout_err;
    logic                             dout_valid;
    logic                             dout_ready;

    modport master (
        input  fifo_empty, mem_rd_data, dec_dataout, dec_err, dout_ready,
        output mem_rd_en, mem_rd_addr, dec_datain, dec_corr, dout, dout_err, dout_valid
    );

    modport slave (
        output fifo_empty, mem_rd_data, dec_dataout, dec_err, dout_ready,
        input  mem_rd_en, mem_rd_addr, dec_datain, dec_corr, dout, dout_err, dout_valid
    );
endinterface

// File: rtl/ecc_rd_ctrl.sv
// ecc_rd_ctrl: pops words from the ECC FIFO RAM, runs them through the SEC-DED decoder, presents them valid/ready.
// Define ECC_ERR_CNT_EN to add the saturating 16-bit err_cnt output alongside the sticky error flag.
module ecc_rd_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ECC_WIDTH  = 7,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    ecc_rd_ctrl_if.master       bus,
    output logic [ADDR_WIDTH:0] rd_ptr,
    output logic                err_sticky,
    input  logic                err_clr
`ifdef ECC_ERR_CNT_EN
    ,
    output logic [15:0]         err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RD, DEC, OUT} state_t;

    state_t state;
    state_t state_next;
    logic   issue;
    logic   load_dec;
    logic   load_out;
    logic   handshake;

    assign handshake = bus.dout_valid & bus.dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new read is only issued from IDLE or on the OUT handshake, so at most one word is ever in flight.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        load_dec   = 1'b0;
        load_out   = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    issue      = 1'b1;
                    state_next = RD;
                end
            end
            RD: begin
                load_dec   = 1'b1;
                state_next = DEC;
            end
            DEC: begin
                load_out   = 1'b1;
                state_next = OUT;
            end
            OUT: begin
                if (handshake) begin
                    if (!bus.fifo_empty) begin
                        issue      = 1'b1;
                        state_next = RD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            issue = 1'b0;
        end
    end

    assign bus.mem_rd_en   = issue;
    assign bus.mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    // The extra MSB toggles on each wrap so the write side can tell full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (issue) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dec_datain <= '0;
            bus.dec_corr   <= '0;
        end else if (load_dec) begin
            bus.dec_datain <= bus.mem_rd_data[DATA_WIDTH-1:0];
            bus.dec_corr   <= bus.mem_rd_data[DATA_WIDTH+ECC_WIDTH-1:DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dout       <= '0;
            bus.dout_err   <= 1'b0;
            bus.dout_valid <= 1'b0;
        end else if (load_out) begin
            bus.dout       <= bus.dec_dataout;
            bus.dout_err   <= bus.dec_err;
            bus.dout_valid <= 1'b1;
        end else if (handshake) begin
            bus.dout_valid <= 1'b0;
        end
    end

    // Setting wins over err_clr so an error delivered in the clearing cycle is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (handshake && bus.dout_err) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

`ifdef ECC_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (handshake && bus.dout_err) begin
            if (err_clr) begin
                err_cnt <= 16'd1;
            end else if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end else if (err_clr) begin
            err_cnt <= '0;
        end
    end
`endif

    assert property (@(posedge clk) disable iff (rst) bus.mem_rd_en |-> !bus.fifo_empty);

    assert property (@(posedge clk) disable iff (rst)
        (bus.dout_valid && !bus.dout_ready) |=> (bus.dout_valid && $stable(bus.dout) && $stable(bus.dout_err)));

endmodule

// File: tb/tb_ecc_rd_ctrl.sv
// Self-checking bench for ecc_rd_ctrl: FIFO RAM model, SEC-DED decoder stub and a queue-based expected-word model.
// Honours ECC_ERR_CNT_EN the same way as the design.
module tb_ecc_rd_ctrl;

    localparam int DW = 32;
    localparam int EW = 7;
    localparam int AW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW:0]   rd_ptr;
    logic          err_sticky;
    logic          err_clr;
`ifdef ECC_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    logic [DW+EW-1:0] mem [0:(2**AW)-1];
    logic [AW:0]      wr_ptr;
    exp_t             exp_q[$];

    int          num_checks = 0;
    int          num_fail   = 0;
    int unsigned cycle      = 0;
    int unsigned issue_cycle = 0;
    logic        inflight     = 1'b0;
    logic        prev_valid   = 1'b0;
    logic        model_sticky = 1'b0;
    logic [15:0] model_cnt    = 16'd0;
    logic [AW-1:0] exp_addr   = '0;

    ecc_rd_ctrl_if #(.DATA_WIDTH(DW), .ECC_WIDTH(EW), .ADDR_WIDTH(AW)) bus ();

    ecc_rd_ctrl #(.DATA_WIDTH(DW), .ECC_WIDTH(EW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rd_ptr     (rd_ptr),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
`ifdef ECC_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Hamming column for data bit i: the i-th code position that is not a power of two.
    function automatic logic [5:0] col(input int i);
        int n = 2;
        int c = -1;
        while (c < i) begin
            n++;
            if ((n & (n - 1)) != 0) c++;
        end
        return n[5:0];
    endfunction

    function automatic logic [5:0] syn_bits(input logic [DW-1:0] d);
        logic [5:0] s = '0;
        for (int i = 0; i < DW; i++) begin
            if (d[i]) s ^= col(i);
        end
        return s;
    endfunction

    function automatic logic [DW+EW-1:0] encode(input logic [DW-1:0] d);
        logic [5:0] c = syn_bits(d);
        return {^{d, c}, c, d};
    endfunction

    function automatic logic [DW:0] decode(input logic [DW+EW-1:0] w);
        logic [DW-1:0] d = w[DW-1:0];
        logic [5:0]    s = syn_bits(w[DW-1:0]) ^ w[DW+5:DW];
        logic          p = ^w;
        logic          e = p | (s != 6'd0);
        if (p) begin
            for (int i = 0; i < DW; i++) begin
                if (col(i) == s) d[i] = ~d[i];
            end
        end
        return {e, d};
    endfunction

    function automatic logic [DW+EW-1:0] randFlip();
        logic [DW+EW-1:0] m = '0;
        int k = $urandom_range(0, 2);
        int a;
        int b;
        if (k == 1) begin
            m[$urandom_range(0, DW + EW - 1)] = 1'b1;
        end else if (k == 2) begin
            a = $urandom_range(0, DW - 1);
            b = (a + 1 + $urandom_range(0, DW - 2)) % DW;
            m[a] = 1'b1;
            m[b] = 1'b1;
        end
        return m;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    end

    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    assign {bus.dec_err, bus.dec_dataout} = decode({bus.dec_corr, bus.dec_datain});

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: handshakes are scored before issues so a same-cycle re-issue sees the previous word retired.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            inflight     = 1'b0;
            prev_valid   = 1'b0;
            model_sticky = 1'b0;
            model_cnt    = 16'd0;
            exp_addr     = '0;
        end else begin
            checkOutput("err_sticky", 64'(err_sticky), 64'(model_sticky));
`ifdef ECC_ERR_CNT_EN
            checkOutput("err_cnt", 64'(err_cnt), 64'(model_cnt));
`endif
            if (bus.dout_valid && !prev_valid) begin
                checkOutput("latency", 64'(cycle - issue_cycle), 64'd3);
            end
            if (bus.dout_valid && bus.dout_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_word", 64'(bus.dout_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("dout", 64'(bus.dout), 64'(e.data));
                    checkOutput("dout_err", 64'(bus.dout_err), 64'(e.err));
                    if (e.err) begin
                        model_sticky = 1'b1;
                        model_cnt    = err_clr ? 16'd1 : ((model_cnt == 16'hFFFF) ? model_cnt : model_cnt + 16'd1);
                    end else if (err_clr) begin
                        model_sticky = 1'b0;
                        model_cnt    = 16'd0;
                    end
                end
                inflight = 1'b0;
            end else if (err_clr) begin
                model_sticky = 1'b0;
                model_cnt    = 16'd0;
            end
            if (bus.mem_rd_en) begin
                checkOutput("rd_addr", 64'(bus.mem_rd_addr), 64'(exp_addr));
                checkOutput("rd_en_while_empty", 64'(bus.fifo_empty), 64'd0);
                checkOutput("rd_en_while_busy", 64'(inflight), 64'd0);
                exp_addr++;
                issue_cycle = cycle;
                inflight    = 1'b1;
            end
            prev_valid = bus.dout_valid;
        end
    end

    task automatic applyStimulus(input logic [DW-1:0] data, input logic [DW+EW-1:0] flip);
        exp_t e;
        int n = 0;
        while ((wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]) && (n < 1000)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) checkOutput("full_wait_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        mem[wr_ptr[AW-1:0]] = encode(data) ^ flip;
        e.err  = (flip != '0);
        e.data = ($countones(flip) == 2) ? (data ^ flip[DW-1:0]) : data;
        exp_q.push_back(e);
        wr_ptr++;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.dout_valid || inflight) && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        wr_ptr     = '0;
        dout_ready_set(1'b1);
        err_clr    = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic dout_ready_set(input logic v);
        bus.dout_ready = v;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rd_ptr"}, 64'(rd_ptr), 64'd0);
        checkOutput({tag, "_mem_rd_en"}, 64'(bus.mem_rd_en), 64'd0);
        checkOutput({tag, "_mem_rd_addr"}, 64'(bus.mem_rd_addr), 64'd0);
        checkOutput({tag, "_dec_datain"}, 64'(bus.dec_datain), 64'd0);
        checkOutput({tag, "_dec_corr"}, 64'(bus.dec_corr), 64'd0);
        checkOutput({tag, "_dout"}, 64'(bus.dout), 64'd0);
        checkOutput({tag, "_dout_err"}, 64'(bus.dout_err), 64'd0);
        checkOutput({tag, "_dout_valid"}, 64'(bus.dout_valid), 64'd0);
        checkOutput({tag, "_err_sticky"}, 64'(err_sticky), 64'd0);
`ifdef ECC_ERR_CNT_EN
        checkOutput({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        rst            = 1'b1;
        wr_ptr         = '0;
        err_clr        = 1'b0;
        bus.dout_ready = 1'b1;

        $display("[TB] reset and idle with empty FIFO");
        applyReset();
        @(negedge clk);
        checkResetValues("reset");
        repeat (10) begin
            @(negedge clk);
            checkOutput("idle_rd_en", 64'(bus.mem_rd_en), 64'd0);
            checkOutput("idle_dout_valid", 64'(bus.dout_valid), 64'd0);
            checkOutput("idle_rd_ptr", 64'(rd_ptr), 64'd0);
        end

        $display("[TB] clean word");
        applyStimulus(32'hDEADBEEF, '0);
        waitDrain();
        checkOutput("rd_ptr_clean", 64'(rd_ptr), 64'd1);

        $display("[TB] single-bit error and err_clr");
        applyStimulus(32'hDEADBEEF, 39'd1 << 5);
        waitDrain();
        checkOutput("sticky_set", 64'(err_sticky), 64'd1);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        checkOutput("sticky_cleared", 64'(err_sticky), 64'd0);

        $display("[TB] double-bit error with consumer stall");
        @(posedge clk); #1 bus.dout_ready = 1'b0;
        applyStimulus(32'hCAFEF00D, (39'd1 << 3) | (39'd1 << 17));
        applyStimulus(32'h12345678, '0);
        n = 0;
        @(negedge clk);
        while (!bus.dout_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("stall_valid_timeout", 64'(n), 64'd0);
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_valid", 64'(bus.dout_valid), 64'd1);
            checkOutput("stall_dout", 64'(bus.dout), 64'h0000_0000_CAFC_F005);
            checkOutput("stall_err", 64'(bus.dout_err), 64'd1);
            checkOutput("stall_no_rd_en", 64'(bus.mem_rd_en), 64'd0);
        end
        @(posedge clk); #1 bus.dout_ready = 1'b1;
        waitDrain();
        checkOutput("rd_ptr_stall", 64'(rd_ptr), 64'(wr_ptr));

        $display("[TB] 17-word stream across pointer wrap");
        applyReset();
        for (int i = 0; i < 17; i++) applyStimulus($urandom, randFlip());
        waitDrain();
        checkOutput("rd_ptr_wrap", 64'(rd_ptr), 64'h11);

        $display("[TB] randomized ready/err_clr traffic");
        fork
            begin
                for (int i = 0; i < 40; i++) applyStimulus($urandom, randFlip());
            end
            begin
                repeat (300) begin
                    @(posedge clk);
                    #1;
                    bus.dout_ready = 1'($urandom_range(0, 1));
                    err_clr        = ($urandom_range(0, 7) == 0);
                end
                @(posedge clk);
                #1;
                bus.dout_ready = 1'b1;
                err_clr        = 1'b0;
            end
        join
        waitDrain();
        checkOutput("rd_ptr_random", 64'(rd_ptr), 64'(wr_ptr));

        $display("[TB] reset while word is in decode");
        applyReset();
        applyStimulus(32'hA5A5_5A5A, '0);
        n = 0;
        @(negedge clk);
        while (!bus.mem_rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) checkOutput("rst_issue_timeout", 64'(n), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        wr_ptr = '0;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkResetValues("midrst");
        repeat (6) begin
            @(negedge clk);
            checkOutput("midrst_no_valid", 64'(bus.dout_valid), 64'd0);
        end

`ifdef ECC_ERR_CNT_EN
        $display("[TB] error counter");
        applyStimulus(32'h0000_0001, 39'd1 << 0);
        applyStimulus(32'h0000_0002, 39'd1 << 35);
        applyStimulus(32'h0000_0003, 39'd1 << 38);
        waitDrain();
        checkOutput("err_cnt_three", 64'(err_cnt), 64'd3);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        checkOutput("err_cnt_cleared", 64'(err_cnt), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
        $finish;
    end

endmodule
